// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect control for the five-stage core, plus the
// trap CSRs (mtvec, mepc, mcause, mstatus) and the RUN/HALT debug FSM.
// Optional feature: define PIPE_CTRL_IRQ_EN to enable external interrupt take.
module pipe_ctrl #(
   parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_busy,
   input  logic        mem_busy,
   input  logic        ld_hazard,
   input  logic        mem_en,
   input  logic [31:0] mem_pc,
   input  logic        exp_en,
   input  logic [3:0]  exp_code,
   input  logic        mret,
   input  logic        halt_req,
   input  logic        resume,
   input  logic        irq,
   input  logic        csr_we,
   input  logic [1:0]  csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        if_stall,
   output logic        id_stall,
   output logic        ex_stall,
   output logic        mem_stall,
   output logic        if_flush,
   output logic        id_flush,
   output logic        ex_flush,
   output logic        mem_flush,
   output logic [31:0] new_pc,
   output logic        halted
);

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

   state_t      r_state;
   logic        r_halted;
   logic [31:0] r_mtvec;
   logic [31:0] r_mepc;
   logic [31:0] r_mcause;
   logic [1:0]  r_mstatus;   // [0] mie, [1] mpie

   logic w_run, w_hlt, w_busy, w_trap, w_ret, w_irq, w_halt_go, w_ld;
   logic w_stall_all, w_redir;

   // Reset gates the combinational controls so the pipeline sees no action
   // while the core is being reset.
   assign w_run = ~reset & (r_state == S_RUN);
   assign w_hlt = ~reset & (r_state == S_HALT);

   // RUN priority chain; each term excludes every higher-priority one.
   assign w_busy = w_run & (if_busy | mem_busy);
   assign w_trap = w_run & ~w_busy & exp_en & mem_en;
   assign w_ret  = w_run & ~w_busy & ~w_trap & mret & mem_en;

`ifdef PIPE_CTRL_IRQ_EN
   assign w_irq = w_run & ~w_busy & ~w_trap & ~w_ret & irq & r_mstatus[0] & mem_en;
`else
   logic w_irq_unused;
   assign w_irq_unused = irq;
   assign w_irq        = 1'b0;
`endif

   assign w_halt_go = w_run & ~w_busy & ~w_trap & ~w_ret & ~w_irq & halt_req;
   assign w_ld      = w_run & ~w_busy & ~w_trap & ~w_ret & ~w_irq & ~w_halt_go & ld_hazard;

   assign w_stall_all = w_busy | w_halt_go | w_hlt;
   assign w_redir     = w_trap | w_ret | w_irq;

   // Load-use holds IF/ID and drops a bubble into ID/EX.
   assign if_stall  = w_stall_all | w_ld;
   assign id_stall  = w_stall_all;
   assign ex_stall  = w_stall_all;
   assign mem_stall = w_stall_all;
   assign if_flush  = w_redir;
   assign id_flush  = w_redir | w_ld;
   assign ex_flush  = w_redir;
   assign mem_flush = w_redir;
   assign halted    = r_halted;

   // Redirect target: return uses the pre-edge mepc, trap/irq use mtvec.
   always_comb begin
      new_pc = 32'h0;
      if (w_ret)               new_pc = r_mepc;
      else if (w_trap | w_irq) new_pc = r_mtvec;
   end

   // RUN/HALT state machine with registered halted flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_RUN;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: if (w_halt_go) begin
               r_state  <= S_HALT;
               r_halted <= 1'b1;
            end
            S_HALT: if (resume) begin
               r_state  <= S_RUN;
               r_halted <= 1'b0;
            end
            default: begin
               r_state  <= S_RUN;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   // Trap CSRs: trap/return/irq updates take precedence over software writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mtvec   <= MTVEC_RST;
         r_mepc    <= 32'h0;
         r_mcause  <= 32'h0;
         r_mstatus <= 2'b00;
      end else begin
         if (csr_we && csr_addr == 2'd0)
            r_mtvec <= {csr_wdata[31:2], 2'b00};

         if (w_trap | w_irq)
            r_mepc <= mem_pc;
         else if (csr_we && csr_addr == 2'd1)
            r_mepc <= {csr_wdata[31:2], 2'b00};

         if (w_trap)
            r_mcause <= {28'h0, exp_code};
         else if (w_irq)
            r_mcause <= 32'h8000_000B;
         else if (csr_we && csr_addr == 2'd2)
            r_mcause <= csr_wdata;

         if (w_trap | w_irq)
            r_mstatus <= {r_mstatus[0], 1'b0};
         else if (w_ret)
            r_mstatus <= {1'b1, r_mstatus[1]};
         else if (csr_we && csr_addr == 2'd3)
            r_mstatus <= csr_wdata[1:0];
      end
   end

   // Combinational CSR read of pre-edge values.
   always_comb begin
      case (csr_addr)
         2'd0:    csr_rdata = r_mtvec;
         2'd1:    csr_rdata = r_mepc;
         2'd2:    csr_rdata = r_mcause;
         default: csr_rdata = {30'h0, r_mstatus};
      endcase
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. Expected values are queued as
// stimulus is driven; observations are queued when sampled; each test drains
// and compares both queues.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        reset, if_busy, mem_busy, ld_hazard, mem_en, exp_en, mret;
   logic        halt_req, resume, irq, csr_we;
   logic [31:0] mem_pc, csr_wdata, csr_rdata, new_pc;
   logic [3:0]  exp_code;
   logic [1:0]  csr_addr;
   logic        if_stall, id_stall, ex_stall, mem_stall;
   logic        if_flush, id_flush, ex_flush, mem_flush, halted;
   logic [8:0]  ctl;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
      .ld_hazard(ld_hazard), .mem_en(mem_en), .mem_pc(mem_pc),
      .exp_en(exp_en), .exp_code(exp_code), .mret(mret),
      .halt_req(halt_req), .resume(resume), .irq(irq),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata),
      .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
      .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
      .ex_flush(ex_flush), .mem_flush(mem_flush), .new_pc(new_pc),
      .halted(halted)
   );

   assign ctl = {if_stall, id_stall, ex_stall, mem_stall,
                 if_flush, id_flush, ex_flush, mem_flush, halted};

   localparam logic [8:0] C_NONE  = 9'b0000_0000_0;
   localparam logic [8:0] C_STALL = 9'b1111_0000_0;
   localparam logic [8:0] C_FLUSH = 9'b0000_1111_0;
   localparam logic [8:0] C_LD    = 9'b1000_0100_0;
   localparam logic [8:0] C_HALT  = 9'b1111_0000_1;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] obs[$];
   int          n_cmp  = 0;
   int          n_fail = 0;

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic push(input string n, input logic [31:0] v);
      sb.push_back('{n, v});
   endtask

   task automatic grab(input logic [31:0] v);
      obs.push_back(v);
   endtask

   task automatic idle();
      reset = 1'b0; if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0;
      mem_en = 1'b0; mem_pc = 32'h0; exp_en = 1'b0; exp_code = 4'h0;
      mret = 1'b0; halt_req = 1'b0; resume = 1'b0; irq = 1'b0;
      csr_we = 1'b0; csr_addr = 2'd0; csr_wdata = 32'h0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      csr_we = 1'b1; csr_addr = a; csr_wdata = d;
      cyc();
      csr_we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      csr_addr = a;
      samp();
      d = csr_rdata;
      cyc();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      exp_t e;
      logic [31:0] o;
      idle();
      reset = 1'b1; mem_busy = 1'b1;
      cyc(); cyc();
      samp();
      push("rst_ctl", 32'(C_NONE)); grab(32'(ctl));
      push("rst_new_pc", 32'h0);    grab(new_pc);
      cyc();
      idle();
      rd(2'd0, d); push("rst_mtvec", 32'h100);  grab(d);
      rd(2'd1, d); push("rst_mepc", 32'h0);     grab(d);
      rd(2'd2, d); push("rst_mcause", 32'h0);   grab(d);
      rd(2'd3, d); push("rst_mstatus", 32'h0);  grab(d);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs.size() == 0) begin n_fail++; $display("FAIL %s: no observation", e.name); end
         else begin
            o = obs.pop_front();
            if (o !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
         end
      end
   endtask

   task automatic test_trap();
      logic [31:0] d;
      exp_t e;
      logic [31:0] o;
      wr(2'd3, 32'h1);
      mem_en = 1'b1; mem_pc = 32'h40; exp_en = 1'b1; exp_code = 4'h2;
      samp();
      push("trap_ctl", 32'(C_FLUSH)); grab(32'(ctl));
      push("trap_new_pc", 32'h100);   grab(new_pc);
      cyc();
      idle();
      rd(2'd1, d); push("trap_mepc", 32'h40);   grab(d);
      rd(2'd2, d); push("trap_mcause", 32'h2);  grab(d);
      rd(2'd3, d); push("trap_mstatus", 32'h2); grab(d);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs.size() == 0) begin n_fail++; $display("FAIL %s: no observation", e.name); end
         else begin
            o = obs.pop_front();
            if (o !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
         end
      end
   endtask

   task automatic test_busy_defer();
      logic [31:0] d;
      exp_t e;
      logic [31:0] o;
      mem_en = 1'b1; mem_pc = 32'h48; exp_en = 1'b1; exp_code = 4'h5;
      mem_busy = 1'b1; csr_addr = 2'd1;
      for (int i = 0; i < 3; i++) begin
         samp();
         push("busy_ctl", 32'(C_STALL)); grab(32'(ctl));
         push("busy_mepc", 32'h40);      grab(csr_rdata);
         cyc();
      end
      mem_busy = 1'b0;
      samp();
      push("busy_rel_ctl", 32'(C_FLUSH)); grab(32'(ctl));
      push("busy_rel_pc", 32'h100);       grab(new_pc);
      cyc();
      idle();
      rd(2'd1, d); push("busy_mepc_after", 32'h48);    grab(d);
      rd(2'd2, d); push("busy_mcause_after", 32'h5);   grab(d);
      rd(2'd3, d); push("busy_mstatus_after", 32'h0);  grab(d);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs.size() == 0) begin n_fail++; $display("FAIL %s: no observation", e.name); end
         else begin
            o = obs.pop_front();
            if (o !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
         end
      end
   endtask

   task automatic test_return();
      logic [31:0] d;
      exp_t e;
      logic [31:0] o;
      wr(2'd1, 32'h47);
      wr(2'd3, 32'hFFFF_FFFE);
      rd(2'd1, d); push("ret_mepc_mask", 32'h44);    grab(d);
      rd(2'd3, d); push("ret_mstatus_mask", 32'h2);  grab(d);
      mret = 1'b1; mem_en = 1'b1;
      samp();
      push("ret_ctl", 32'(C_FLUSH)); grab(32'(ctl));
      push("ret_new_pc", 32'h44);    grab(new_pc);
      cyc();
      idle();
      rd(2'd3, d); push("ret_mstatus", 32'h3); grab(d);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs.size() == 0) begin n_fail++; $display("FAIL %s: no observation", e.name); end
         else begin
            o = obs.pop_front();
            if (o !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
         end
      end
   endtask

   task automatic test_load_use();
      logic [31:0] d;
      exp_t e;
      logic [31:0] o;
      ld_hazard = 1'b1;
      samp();
      push("ld_ctl", 32'(C_LD)); grab(32'(ctl));
      cyc();
      // trap outranks load-use and beats a same-cycle mepc write
      csr_we = 1'b1; csr_addr = 2'd1; csr_wdata = 32'h80;
      exp_en = 1'b1; mem_en = 1'b1; mem_pc = 32'h20; exp_code = 4'h3;
      samp();
      push("coll_ctl", 32'(C_FLUSH)); grab(32'(ctl));
      cyc();
      idle();
      rd(2'd1, d); push("coll_mepc", 32'h20);    grab(d);
      rd(2'd2, d); push("coll_mcause", 32'h3);   grab(d);
      rd(2'd3, d); push("coll_mstatus", 32'h2);  grab(d);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs.size() == 0) begin n_fail++; $display("FAIL %s: no observation", e.name); end
         else begin
            o = obs.pop_front();
            if (o !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
         end
      end
   endtask

   task automatic test_halt();
      exp_t e;
      logic [31:0] o;
      halt_req = 1'b1;
      samp();
      push("halt_go_ctl", 32'(C_STALL)); grab(32'(ctl));
      cyc();
      halt_req = 1'b0; exp_en = 1'b1; mem_en = 1'b1; mem_pc = 32'h99; csr_addr = 2'd1;
      for (int i = 0; i < 2; i++) begin
         samp();
         push("halt_ctl", 32'(C_HALT)); grab(32'(ctl));
         push("halt_mepc", 32'h20);     grab(csr_rdata);
         cyc();
      end
      exp_en = 1'b0; mem_en = 1'b0; resume = 1'b1;
      samp();
      push("resume_cyc_ctl", 32'(C_HALT)); grab(32'(ctl));
      cyc();
      resume = 1'b0;
      samp();
      push("run_after_ctl", 32'(C_NONE)); grab(32'(ctl));
      cyc();
      resume = 1'b1;
      samp();
      push("resume_in_run", 32'(C_NONE)); grab(32'(ctl));
      cyc();
      resume = 1'b0;
      samp();
      push("resume_ignored", 32'(C_NONE)); grab(32'(ctl));
      cyc();
      idle();
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs.size() == 0) begin n_fail++; $display("FAIL %s: no observation", e.name); end
         else begin
            o = obs.pop_front();
            if (o !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
         end
      end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      exp_t e;
      logic [31:0] o;
      wr(2'd3, 32'h1);
      irq = 1'b1; mem_en = 1'b1; mem_pc = 32'h60;
      samp();
`ifdef PIPE_CTRL_IRQ_EN
      push("irq_ctl", 32'(C_FLUSH)); grab(32'(ctl));
      push("irq_new_pc", 32'h100);   grab(new_pc);
      cyc();
      idle();
      rd(2'd2, d); push("irq_mcause", 32'h8000_000B); grab(d);
      rd(2'd1, d); push("irq_mepc", 32'h60);          grab(d);
      rd(2'd3, d); push("irq_mstatus", 32'h2);        grab(d);
`else
      push("irq_off_ctl", 32'(C_NONE)); grab(32'(ctl));
      cyc();
      idle();
      rd(2'd3, d); push("irq_off_mstatus", 32'h1); grab(d);
      rd(2'd1, d); push("irq_off_mepc", 32'h20);   grab(d);
`endif
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs.size() == 0) begin n_fail++; $display("FAIL %s: no observation", e.name); end
         else begin
            o = obs.pop_front();
            if (o !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      exp_t e;
      logic [31:0] o;
      wr(2'd3, 32'h1);
      mem_en = 1'b1; exp_en = 1'b1; mem_pc = 32'h70; exp_code = 4'h7;
      samp();
      push("b2b_trap_ctl", 32'(C_FLUSH)); grab(32'(ctl));
      push("b2b_trap_pc", 32'h100);       grab(new_pc);
      cyc();
      exp_en = 1'b0; mret = 1'b1;
      samp();
      push("b2b_ret_ctl", 32'(C_FLUSH)); grab(32'(ctl));
      push("b2b_ret_pc", 32'h70);        grab(new_pc);
      cyc();
      idle();
      rd(2'd3, d); push("b2b_mstatus", 32'h3); grab(d);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs.size() == 0) begin n_fail++; $display("FAIL %s: no observation", e.name); end
         else begin
            o = obs.pop_front();
            if (o !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
         end
      end
   endtask

   task automatic test_reset_in_halt();
      logic [31:0] d;
      exp_t e;
      logic [31:0] o;
      wr(2'd0, 32'h203);
      rd(2'd0, d); push("mtvec_mask", 32'h200); grab(d);
      halt_req = 1'b1;
      cyc();
      halt_req = 1'b0;
      samp();
      push("pre_rst_halt", 32'(C_HALT)); grab(32'(ctl));
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      samp();
      push("post_rst_ctl", 32'(C_NONE)); grab(32'(ctl));
      cyc();
      rd(2'd0, d); push("post_rst_mtvec", 32'h100);  grab(d);
      rd(2'd1, d); push("post_rst_mepc", 32'h0);     grab(d);
      rd(2'd3, d); push("post_rst_mstatus", 32'h0);  grab(d);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs.size() == 0) begin n_fail++; $display("FAIL %s: no observation", e.name); end
         else begin
            o = obs.pop_front();
            if (o !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
         end
      end
   endtask

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      test_trap();
      test_busy_defer();
      test_return();
      test_load_use();
      test_halt();
      test_irq();
      test_back_to_back();
      test_reset_in_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
